// File: rtl/coin_entry_ctrl_pkg.sv
// Shared types and constants for the coin entry front-end.
// Holds the FSM state encoding and the saturating coin counter helper.
package coin_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DEBOUNCE,
        HOLD,
        WAIT_REL
    } coin_state_t;

    localparam int COIN_W = 8;
    localparam logic [COIN_W-1:0] COIN_CNT_MAX = 8'd255;

    function automatic logic [COIN_W-1:0] sat_inc(
        input logic [COIN_W-1:0] v
    );
        return (v == COIN_CNT_MAX) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/coin_entry_ctrl_if.sv
// Button/switch inputs and coin event outputs of the coin front-end.
// master = stimulus/driver side, slave = coin_entry_ctrl.
interface coin_entry_ctrl_if;
    import coin_pkg::*;

    logic              btn_raw;
    logic [COIN_W-1:0] sw_val;
    logic              c;
    logic [COIN_W-1:0] a;
    logic              rej;
    logic [COIN_W-1:0] coin_cnt;

    modport master (
        output btn_raw, sw_val,
        input  c, a, rej, coin_cnt
    );

    modport slave (
        input  btn_raw, sw_val,
        output c, a, rej, coin_cnt
    );

endinterface

// File: rtl/coin_entry_ctrl_sync2.sv
// Two-flop synchroniser for asynchronous inputs, cleared on reset.
// Width is parameterised so one module serves button and switches.
module sync2 #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] s1;

    // Two register stages to resolve metastability
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1 <= '0;
            q  <= '0;
        end else begin
            s1 <= d;
            q  <= s1;
        end
    end

endmodule

// File: rtl/coin_entry_ctrl.sv
// Debounces the coin button and emits one stretched coin strobe per press.
// The strobe is held long enough for the slow vending FSM to see it once.
module coin_entry_ctrl
    import coin_pkg::*;
#(
    parameter int DB_CYCLES   = 1_000_000,
    parameter int HOLD_CYCLES = 33_554_432
) (
    input  logic               sys_clk,
    input  logic               reset,
    coin_entry_ctrl_if.slave   bus
);

    localparam int CNT_MAX =
        (DB_CYCLES > HOLD_CYCLES) ? DB_CYCLES : HOLD_CYCLES;
    localparam int CNT_W = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic              btn_s;
    logic [COIN_W-1:0] sw_s;

    coin_state_t       state;
    logic [CNT_W-1:0]  cnt;
    logic              c_q;
    logic [COIN_W-1:0] a_q;
    logic              rej_q;
    logic [COIN_W-1:0] coin_cnt_q;

    sync2 #(.W(1)) u_sync_btn (
        .clk   (sys_clk),
        .rst_n (reset),
        .d     (bus.btn_raw),
        .q     (btn_s)
    );

    sync2 #(.W(COIN_W)) u_sync_sw (
        .clk   (sys_clk),
        .rst_n (reset),
        .d     (bus.sw_val),
        .q     (sw_s)
    );

    // Press/hold/release sequencing with registered coin outputs.
    // The sample that leaves IDLE is the first stable cycle, so cnt
    // starts at 1 in DEBOUNCE.
    always_ff @(posedge sys_clk) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            c_q        <= 1'b0;
            a_q        <= '0;
            rej_q      <= 1'b0;
            coin_cnt_q <= '0;
        end else begin
            rej_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (btn_s) begin
                        state <= DEBOUNCE;
                        cnt   <= CNT_ONE;
                    end else begin
                        cnt <= '0;
                    end
                end
                DEBOUNCE: begin
                    if (!btn_s) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (cnt == DB_LAST) begin
                        cnt <= '0;
                        if (sw_s != '0) begin
                            a_q        <= sw_s;
                            c_q        <= 1'b1;
                            coin_cnt_q <= sat_inc(coin_cnt_q);
                            state      <= HOLD;
                        end else begin
                            rej_q <= 1'b1;
                            state <= WAIT_REL;
                        end
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                HOLD: begin
                    if (cnt == HOLD_LAST) begin
                        c_q   <= 1'b0;
                        cnt   <= '0;
                        state <= WAIT_REL;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                WAIT_REL: begin
                    if (btn_s) begin
                        cnt <= '0;
                    end else if (cnt == DB_LAST) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                    c_q   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.c        = c_q;
    assign bus.a        = a_q;
    assign bus.rej      = rej_q;
    assign bus.coin_cnt = coin_cnt_q;

endmodule
